// File: rtl/quine_uart_streamer.sv
// quine_uart_streamer: walks a byte ROM that holds the design's own source
// text and sends each byte as one UART frame (start bit, 8 data bits LSB
// first, optional even parity, STOP_BITS stop bits). Each bit lasts CLK_DIV
// clocks. One FETCH cycle of idle line separates consecutive frames.
//
// Build option: define QUINE_PARITY_EN to insert an even-parity bit after
// data bit 7. Without the macro no parity logic exists.
module quine_uart_streamer #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [7:0]        byte_data,
  output logic              byte_valid
);

`ifdef QUINE_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif

  // Whole frame including the start bit; the shifter holds everything after it.
  localparam int unsigned FRAME_BITS = 9 + STOP_BITS + PAR_BITS;
  localparam int unsigned SHIFT_W    = FRAME_BITS - 1;
  localparam int unsigned CNT_W      = $clog2(CLK_DIV);
  localparam int unsigned IDX_W      = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_BITS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t             state;
  logic [SHIFT_W-1:0] shifter;
  logic [CNT_W-1:0]   bit_cnt;
  logic [IDX_W-1:0]   bit_idx;
  logic [SHIFT_W-1:0] frame_load;

  // Bits that follow the start bit, in transmit order from bit 0 upward.
`ifdef QUINE_PARITY_EN
  assign frame_load = {{STOP_BITS{1'b1}}, ^rom_data, rom_data};
`else
  assign frame_load = {{STOP_BITS{1'b1}}, rom_data};
`endif

  // Playback FSM: address walk, bit timing, line driver and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rom_addr   <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      shifter    <= '0;
      bit_cnt    <= '0;
      bit_idx    <= '0;
    end else begin
      // NOTE: non-blocking defaults make done/byte_valid single-cycle pulses;
      // any branch below that assigns them later in this block wins.
      done       <= 1'b0;
      byte_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            rom_addr <= '0;
            busy     <= 1'b1;
          end
        end

        // rom_data for the current address is valid at the end of this cycle.
        FETCH: begin
          state      <= SEND;
          shifter    <= frame_load;
          byte_data  <= rom_data;
          byte_valid <= 1'b1;
          tx         <= 1'b0;
          bit_cnt    <= '0;
          bit_idx    <= '0;
        end

        SEND: begin
          if (bit_cnt != CNT_LAST) begin
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            bit_cnt <= '0;
            if (bit_idx != IDX_LAST) begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shifter[0];
              shifter <= {1'b1, shifter[SHIFT_W-1:1]};
            end else begin
              // End of the last stop bit: the line stays high from here on.
              tx      <= 1'b1;
              bit_idx <= '0;
              if (rom_addr != ADDR_LAST) begin
                rom_addr <= rom_addr + 1'b1;
                state    <= FETCH;
              end else if (loop) begin
                rom_addr <= '0;
                state    <= FETCH;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quine_uart_streamer.sv
// tb_quine_uart_streamer: directed bench for quine_uart_streamer with a
// 4-byte image (41 42 43 0A), CLK_DIV=4, STOP_BITS=1. A bench-side UART
// decoder recovers the bytes from tx; monitors log byte_valid, done and
// address wraps. Build with QUINE_PARITY_EN to also check the parity bit.
module tb_quine_uart_streamer;

  localparam int DEPTH     = 4;
  localparam int CLK_DIV   = 4;
  localparam int STOP_BITS = 1;
`ifdef QUINE_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 10 + STOP_BITS - 1 + P;  // bits per frame
  localparam int F  = CLK_DIV * NB;            // clocks per frame

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       loop  = 1'b0;
  logic [1:0] rom_addr;
  logic [7:0] rom_data;
  logic       tx;
  logic       busy;
  logic       done;
  logic [7:0] byte_data;
  logic       byte_valid;

  logic [7:0] rom [DEPTH] = '{8'h41, 8'h42, 8'h43, 8'h0A};
  logic [7:0] exp_seq [DEPTH] = '{8'h41, 8'h42, 8'h43, 8'h0A};
  logic       exp_par [DEPTH] = '{1'b0, 1'b0, 1'b1, 1'b0};

  // Source ROM model: data for rom_addr is ready by the next rising edge.
  assign rom_data = rom[rom_addr];

  quine_uart_streamer #(
    .DEPTH    (DEPTH),
    .CLK_DIV  (CLK_DIV),
    .STOP_BITS(STOP_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .loop      (loop),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .tx        (tx),
    .busy      (busy),
    .done      (done),
    .byte_data (byte_data),
    .byte_valid(byte_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // cyc = index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk) cyc++;

  int         done_cnt     = 0;
  int         done_cyc     = -1;
  int         wrap_cnt     = 0;
  int         busy_at_done = 0;
  logic [1:0] prev_addr    = 2'd0;
  logic [7:0] bv_q [$];

  // Monitors sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy !== 1'b0) busy_at_done++;
    end
    if (byte_valid === 1'b1) bv_q.push_back(byte_data);
    if (prev_addr == 2'd3 && rom_addr == 2'd0) wrap_cnt++;
    prev_addr = rom_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_low(input int budget, output bit ok);
    int n = 0;
    while (tx !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (tx === 1'b0);
  endtask

  // Decode one frame; optionally pulse start right after data bit poke_bit.
  // Returns during the first cycle of the last stop bit.
  task automatic rx_byte(input int poke_bit, output logic [7:0] b, output logic par);
    bit ok;
    int skip = 0;
    b   = '0;
    par = 1'b0;
    wait_low(3 * F, ok);
    check("rx_start_seen", 32'(ok), 32'd1);
    if (!ok) return;
    for (int i = 0; i < 8; i++) begin
      repeat (CLK_DIV - skip) @(negedge clk);
      skip = 0;
      b[i] = tx;
      if (i == poke_bit) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        skip  = 1;
      end
    end
`ifdef QUINE_PARITY_EN
    repeat (CLK_DIV) @(negedge clk);
    par = tx;
`endif
    for (int s = 0; s < STOP_BITS; s++) begin
      repeat (CLK_DIV) @(negedge clk);
      check("rx_stop_bit", 32'(tx), 32'd1);
    end
  endtask

  task automatic wait_done(input int d_ref, output bit ok);
    int n = 0;
    while (done_cnt == d_ref && n < DEPTH * (F + 1) * 2) begin
      @(negedge clk);
      n++;
    end
    ok = (done_cnt != d_ref);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rx_image(input string tag);
    logic [7:0] b;
    logic       par;
    for (int i = 0; i < DEPTH; i++) begin
      rx_byte(-1, b, par);
      check($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(exp_seq[i]));
`ifdef QUINE_PARITY_EN
      check($sformatf("%s_par%0d", tag, i), 32'(par), 32'(exp_par[i]));
`endif
    end
  endtask

  initial begin
    logic [7:0] b;
    logic       par;
    bit         ok;
    int         k, d0, q0, w0, bad;

    // Reset held 3 cycles with start high: outputs stay at idle values.
    rst   = 1'b1;
    start = 1'b1;
    loop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst%0d_tx", i),   32'(tx),       32'd1);
      check($sformatf("rst%0d_busy", i), 32'(busy),     32'd0);
      check($sformatf("rst%0d_done", i), 32'(done),     32'd0);
      check($sformatf("rst%0d_addr", i), 32'(rom_addr), 32'd0);
    end
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_byte_data",  32'(byte_data),  32'd0);
    rst   = 1'b0;
    start = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_no_frame", 32'(bad), 32'd0);

    // One-shot playback with start-edge timing.
    d0 = done_cnt;
    q0 = bv_q.size();
    start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    check("fetch_busy", 32'(busy),       32'd1);
    check("fetch_tx",   32'(tx),         32'd1);
    check("fetch_addr", 32'(rom_addr),   32'd0);
    check("fetch_bv",   32'(byte_valid), 32'd0);
    @(negedge clk);
    check("first_start_bit", 32'(tx),         32'd0);
    check("first_bv",        32'(byte_valid), 32'd1);
    check("first_byte_data", 32'(byte_data),  32'h41);
    rx_image("oneshot");
    wait_done(d0, ok);
    check("oneshot_done_seen", 32'(ok), 32'd1);
    // done_cyc is the edge that raised done; the done cycle ends one edge later.
    check("oneshot_latency", 32'(done_cyc - k + 1), 32'(DEPTH * (F + 1) + 1));
    check("oneshot_done_once", 32'(done_cnt - d0), 32'd1);
    check("oneshot_busy_low", 32'(busy), 32'd0);
    check("oneshot_bv_count", 32'(bv_q.size() - q0), 32'd4);
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("oneshot_bv%0d", i), 32'(bv_q[q0 + i]), 32'(exp_seq[i]));

    // Loop: two full passes, loop dropped during byte 2 of pass 3.
    d0 = done_cnt;
    q0 = bv_q.size();
    w0 = 0;
    loop = 1'b1;
    pulse_start();
    for (int n = 0; n < 3 * DEPTH; n++) begin
      rx_byte(-1, b, par);
      check($sformatf("loop_byte%0d", n), 32'(b), 32'(exp_seq[n % DEPTH]));
      if (n == 0) w0 = wrap_cnt;
      if (n == DEPTH * 2 + 1) loop = 1'b0;
    end
    wait_done(d0, ok);
    check("loop_done_seen", 32'(ok), 32'd1);
    check("loop_wraps", 32'(wrap_cnt - w0), 32'd2);
    check("loop_bv_count", 32'(bv_q.size() - q0), 32'(3 * DEPTH));
    bad = 0;
    repeat (2 * F) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("loop_stopped_quiet", 32'(bad), 32'd0);
    check("loop_done_once", 32'(done_cnt - d0), 32'd1);

    // Start pulsed mid-byte while busy: stream continues undisturbed.
    d0 = done_cnt;
    q0 = bv_q.size();
    pulse_start();
    rx_byte(-1, b, par);
    check("busy_byte0", 32'(b), 32'h41);
    rx_byte(3, b, par);
    check("busy_byte1", 32'(b), 32'h42);
    check("busy_start_addr", 32'(rom_addr), 32'd1);
    check("busy_still_busy", 32'(busy), 32'd1);
    rx_byte(-1, b, par);
    check("busy_byte2", 32'(b), 32'h43);
    rx_byte(-1, b, par);
    check("busy_byte3", 32'(b), 32'h0A);
    wait_done(d0, ok);
    check("busy_done_seen", 32'(ok), 32'd1);
    check("busy_done_once", 32'(done_cnt - d0), 32'd1);
    check("busy_bv_count", 32'(bv_q.size() - q0), 32'd4);

    // Reset during data bit 3 of byte 42, then replay from the start.
    d0 = done_cnt;
    pulse_start();
    rx_byte(-1, b, par);
    check("rstmid_byte0", 32'(b), 32'h41);
    wait_low(2 * F, ok);
    check("rstmid_start_seen", 32'(ok), 32'd1);
    repeat (4 * CLK_DIV) @(negedge clk);
    check("rstmid_bit3_low", 32'(tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_tx",   32'(tx),       32'd1);
    check("rstmid_busy", 32'(busy),     32'd0);
    check("rstmid_done", 32'(done),     32'd0);
    check("rstmid_addr", 32'(rom_addr), 32'd0);
    bad = 0;
    repeat (2 * F) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("rstmid_quiet", 32'(bad), 32'd0);
    check("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
    pulse_start();
    rx_image("replay");
    wait_done(d0, ok);
    check("replay_done_seen", 32'(ok), 32'd1);
    check("replay_done_once", 32'(done_cnt - d0), 32'd1);

    check("busy_low_with_done", 32'(busy_at_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quine_uart_streamer.md
# quine_uart_streamer

Parametrised source-image streamer for the quine tile: walks an external byte ROM holding the design's own source text and serialises each byte onto an 8-N-1 (optionally 8-E-1) UART line at a configurable bit period. Supports one-shot and continuous-loop playback, and exposes each byte on a parallel tap for on-chip debug or a second output channel. Sits between the source ROM and the `uo_out` pin mux of the top-level tile.

## Interface
- `DEPTH`, default 1024: number of bytes in the source image. Must be at least 1.
- `ADDR_W`, default `$clog2(DEPTH)` (minimum 1): ROM address width.
- `CLK_DIV`, default 16: clocks per UART bit. Must be at least 2.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin playback from address 0. Sampled only in IDLE.
- `loop` input 1: after the last byte, wrap to address 0 instead of stopping.
- `rom_addr` output ADDR_W: ROM read address.
- `rom_data` input 8: ROM read data, valid exactly one clock after `rom_addr`.
- `tx` output 1: UART line. Idles high.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse when one-shot playback completes.
- `byte_data` output 8: last byte captured from the ROM.
- `byte_valid` output 1: one-cycle pulse on the capture cycle.

## Operation
- States:
  - IDLE: `tx`=1.
  - FETCH: drive `rom_addr`; `tx`=1.
  - SEND: shift out the frame.
- Transitions:
  - IDLE -> FETCH on `start`=1. The address is set to 0.
  - FETCH -> SEND after exactly 1 cycle. On entry to SEND, capture `rom_data` into the shifter and `byte_data`, and pulse `byte_valid`.
  - SEND -> FETCH at the end of the last stop bit when the address is below DEPTH-1. The address increments.
  - SEND -> FETCH at the end of the last stop bit when the address equals DEPTH-1 and `loop`=1. The address wraps to 0.
  - SEND -> IDLE at the end of the last stop bit when the address equals DEPTH-1 and `loop`=0. `done` pulses on the first IDLE cycle.
- `loop` is sampled only at the end of the final byte's last stop bit. Deasserting it mid-image finishes the current pass, then stops.
- Frame order:
  - 1 start bit (0).
  - 8 data bits, LSB first.
  - Parity bit, only when `QUINE_PARITY_EN` is defined (see Configuration).
  - STOP_BITS stop bits (1).
- Each bit is held for exactly CLK_DIV clocks. Use a bit-period counter of width `$clog2(CLK_DIV)` and a bit index counter.
- `start` while `busy`=1 is ignored. Playback is not restarted.
- `start` held high continuously in one-shot mode: playback restarts from IDLE on the cycle after `done`.
- Reset values: `tx`=1, `busy`=0, `done`=0, `byte_valid`=0, `byte_data`=0, `rom_addr`=0, state IDLE, all counters 0.
- Reset asserted mid-frame: `tx`=1 from the cycle after the reset edge. There is no partial stop bit and no `done` pulse.

## Timing
- Let `start` be sampled high at edge k:
  - FETCH during cycle k..k+1, with `rom_addr`=0.
  - `tx`=0 (start bit) and `byte_valid`=1 in cycle k+1..k+2.
- Frame length F = CLK_DIV × (10 + STOP_BITS − 1 + P) clocks, where P=1 with parity and 0 without.
- Inter-byte gap: exactly 1 extra clock of `tx`=1 (the FETCH cycle) between the last stop bit and the next start bit.
- One-shot image time, `start` edge to the first `done` cycle: DEPTH × (F + 1) + 1 clocks.
- `busy` rises the cycle after `start` is sampled. It falls in the same cycle `done` is asserted.

## Configuration
- `QUINE_PARITY_EN` defined:
  - An even-parity bit (XOR of the 8 data bits) is inserted after bit 7.
  - Frame is 11 + (STOP_BITS − 1) bits.
- `QUINE_PARITY_EN` undefined:
  - No parity bit; 8-N-STOP_BITS framing.
  - No parity logic is synthesised.

## Test plan
- Reset and idle: assert `rst` for 3 cycles while `start`=1 -> `tx`=1, `busy`=0, `done`=0, `rom_addr`=0 throughout, and no frame after release until `start` is sampled.
- One-shot: DEPTH=4, CLK_DIV=4, STOP_BITS=1, ROM = 41 42 43 0A, `loop`=0, no parity.
  - Decoder receives exactly 41 42 43 0A.
  - `byte_valid` pulses 4 times with the same values.
  - `done` pulses once, 4×41+1 = 165 clocks after the `start` edge.
- Loop wrap: same ROM with `loop`=1 for 2 passes, then drop `loop` during byte 2 of pass 3.
  - Receives 41 42 43 0A three times, then stops with a single `done`.
  - `rom_addr` goes 3 -> 0 at each wrap.
- Start while busy: pulse `start` mid-byte 1 -> stream unchanged, and `rom_addr` does not return to 0.
- Reset mid-frame: assert `rst` during data bit 3 of byte 42 -> `tx`=1 on the next cycle, no `done`, and a new `start` replays from 41.
- Parity build: `QUINE_PARITY_EN` defined, byte 43 -> parity bit 1; byte 41 -> parity bit 0.
